laser_pt_source: RTL and testbench
==================================

Name: laser_pt_source

Overview:
- Drives the LASER solver from the other side of its interface.
- Holds a 40-point test pattern loaded by a host, pulses the solver's reset, and streams the points on X/Y one per cycle.
- Waits for DONE, captures C1/C2, then independently scores how many points the returned circles cover.
- Used as the on-chip stimulus/checker around the solver and as the reusable bench driver.

Parameters:
- PT_NUM, 40, points per pattern.
- RADIUS, 4, circle radius; a point is covered iff dx*dx+dy*dy <= RADIUS*RADIUS.
- RST_CYCLES, 2, cycles LASER_RST is held high per run (>=1).
- TIMEOUT_CYC, 8191, maximum WAIT cycles before a run is declared timed out.

Ports:
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- WR_EN  in  1  host point write strobe
- WR_ADDR  in  6  point index 0..PT_NUM-1
- WR_X  in  4  point X
- WR_Y  in  4  point Y
- START  in  1  one-cycle run request
- LASER_RST  out  1  sync active-high reset to solver
- X  out  4  streamed point X to solver
- Y  out  4  streamed point Y to solver
- C1X, C1Y, C2X, C2Y  in  4 each  solver result
- DONE  in  1  solver completion
- BUSY  out  1  run in progress
- RES_VALID  out  1  one-cycle result strobe
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres
- SCORE  out  6  covered-point count, 0..PT_NUM
- TIMEOUT  out  1  last run timed out

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous and active-low.
- Reset values: LASER_RST=1 (solver held in reset); all other outputs 0. Point memory is not reset. State returns to IDLE.
- All outputs are registered.
- States: IDLE, RSTD, SEND, WAIT, SCORE, REPORT.
- IDLE:
  - LASER_RST=0, X=Y=0, BUSY=0.
  - WR_EN with WR_ADDR<PT_NUM writes the point; WR_ADDR>=PT_NUM is dropped.
  - START=1 -> RSTD; BUSY=1 from the next cycle. A write and START in the same cycle: the write lands first.
- RSTD:
  - LASER_RST=1 for exactly RST_CYCLES cycles, then -> SEND.
- SEND:
  - Index i runs 0..PT_NUM-1, one point per cycle.
  - The cycle immediately after the last LASER_RST-high cycle carries X/Y = pt[0]; the next carries pt[1]; and so on, with no gaps.
  - After pt[PT_NUM-1] -> WAIT, with X=Y=0.
  - DONE is ignored in SEND.
- WAIT:
  - A cycle counter starts at 0.
  - DONE=1 sampled: capture C1X..C2Y into RES_*, clear SCORE, -> SCORE.
  - Counter reaches TIMEOUT_CYC with no DONE: TIMEOUT=1, SCORE=0, RES_* =0, -> REPORT.
  - If both happen on the same edge, DONE wins.
- SCORE:
  - One point per cycle, i = 0..PT_NUM-1.
  - dx=|px-cx| and dy=|py-cy| as 4-bit values; squares are 8 bits; the sum is 9 bits.
  - A point covered by C1 or C2 (or both) counts once.
  - The accumulator is 6 bits and saturates at PT_NUM.
  - After the last point -> REPORT.
- REPORT:
  - RES_VALID=1 for exactly one cycle, then -> IDLE.
  - BUSY drops the same cycle RES_VALID rises.
  - RES_VALID rises exactly PT_NUM+1 cycles after the edge at which DONE was sampled high.
- Result outputs: RES_*, SCORE and TIMEOUT hold until the next accepted START. START clears TIMEOUT.
- While BUSY: START and WR_EN are ignored, so memory stays stable during a run.
- RST_N asserted mid-run: immediate abort. LASER_RST=1, state IDLE, no RES_VALID.

Test Plan:
- Load pt[i]=(i%16, i/16). START -> after the RST_CYCLES=2 LASER_RST-high cycles, X/Y show (0,0),(1,0)…(15,0),(0,1)… in consecutive cycles, 40 cycles total, then 0.
- Model solver asserts DONE in WAIT cycle 100 with C1=(4,4), C2=(11,4). Pattern: 20 points at (4,4), 15 at (11,5), 5 at (0,15) -> RES_VALID exactly 41 cycles after DONE, SCORE=35, RES_C1X=4, RES_C2X=11, TIMEOUT=0.
- Boundary: points (8,4) [d²=16] and (8,5) [d²=17], C1=C2=(4,4), remaining 38 points at (4,4) -> SCORE=39; both circles covering a point counts it once.
- DONE never asserted -> TIMEOUT=1 and RES_VALID after 8191 WAIT cycles, SCORE=0. A DONE pulse during SEND is ignored.
- START and WR_EN pulsed mid-SEND -> no restart, memory unchanged. WR_ADDR=45 write in IDLE -> memory unchanged.
- RST_N low during WAIT -> LASER_RST=1, BUSY=0, no RES_VALID. A new START after release runs a clean full sequence.

Source files
------------

// File: rtl/laser_pt_source.sv
`timescale 1ns/1ps
// laser_pt_source: stimulus/checker wrapped around the LASER solver.
// A host loads a PT_NUM-point pattern. START resets the solver, streams the
// points on X/Y and waits for DONE. It then captures the two circle centres
// and counts how many points they cover.
// Handshake: START is a one-cycle request taken only while BUSY=0.
// DONE is a level that is sampled only in WAIT. RES_VALID is a one-cycle strobe
// that rises in the same cycle BUSY falls.
// RES_*, SCORE and TIMEOUT stay stable from that strobe until the next
// accepted START.
module laser_pt_source #(
    parameter int unsigned PT_NUM      = 40,
    parameter int unsigned RADIUS      = 4,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYC = 8191
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WR_EN,
    input  logic [5:0] WR_ADDR,
    input  logic [3:0] WR_X,
    input  logic [3:0] WR_Y,
    input  logic       START,
    output logic       LASER_RST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic       BUSY,
    output logic       RES_VALID,
    output logic [3:0] RES_C1X,
    output logic [3:0] RES_C1Y,
    output logic [3:0] RES_C2X,
    output logic [3:0] RES_C2Y,
    output logic [5:0] SCORE,
    output logic       TIMEOUT,
    output logic [2:0] DBG_STATE
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0]  R2 = 9'(RADIUS * RADIUS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RSTD   = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_SCORE  = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [5:0]      nxt_idx;
    logic            laser_rst_q, laser_rst_d;
    logic [3:0]      x_q, x_d, y_q, y_d;
    logic            busy_q, busy_d;
    logic            res_valid_q, res_valid_d;
    logic [3:0]      c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0]      score_q, score_d;
    logic            timeout_q, timeout_d;
    logic            hit;

    // Point memory has no reset; the host always loads it before a run.
    logic [3:0] pt_x [PT_NUM];
    logic [3:0] pt_y [PT_NUM];

    // Squared-distance test with the stated bit widths (4-bit |d|, 9-bit sum).
    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [7:0] dx2, dy2;
        logic [8:0] d2;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        dx2 = {4'd0, dx} * {4'd0, dx};
        dy2 = {4'd0, dy} * {4'd0, dy};
        d2  = {1'b0, dx2} + {1'b0, dy2};
        return d2 <= R2;
    endfunction

    // Host writes land only in IDLE, so the pattern is frozen during a run.
    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && WR_EN && WR_ADDR < 6'(PT_NUM)) begin
            pt_x[WR_ADDR] <= WR_X;
            pt_y[WR_ADDR] <= WR_Y;
        end
    end

    assign nxt_idx = idx_q + 6'd1;
    // A point counts once even if both circles cover it.
    assign hit = in_circle(pt_x[idx_q], pt_y[idx_q], c1x_q, c1y_q) ||
                 in_circle(pt_x[idx_q], pt_y[idx_q], c2x_q, c2y_q);

    // Next-state and registered-output logic for the run sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        laser_rst_d = laser_rst_q;
        x_d         = x_q;
        y_d         = y_q;
        busy_d      = busy_q;
        res_valid_d = 1'b0;
        c1x_d       = c1x_q;
        c1y_d       = c1y_q;
        c2x_d       = c2x_q;
        c2y_d       = c2y_q;
        score_d     = score_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                laser_rst_d = 1'b0;
                x_d         = 4'd0;
                y_d         = 4'd0;
                busy_d      = 1'b0;
                if (START) begin
                    state_d     = S_RSTD;
                    laser_rst_d = 1'b1;
                    busy_d      = 1'b1;
                    timeout_d   = 1'b0;
                    cnt_d       = '0;
                end
            end
            S_RSTD: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d     = S_SEND;
                    laser_rst_d = 1'b0;
                    idx_d       = 6'd0;
                    x_d         = pt_x[0];
                    y_d         = pt_y[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (idx_q == 6'(PT_NUM - 1)) begin
                    state_d = S_WAIT;
                    x_d     = 4'd0;
                    y_d     = 4'd0;
                    cnt_d   = '0;
                end else begin
                    idx_d = nxt_idx;
                    x_d   = pt_x[nxt_idx];
                    y_d   = pt_y[nxt_idx];
                end
            end
            S_WAIT: begin
                if (DONE) begin
                    state_d = S_SCORE;
                    c1x_d   = C1X;
                    c1y_d   = C1Y;
                    c2x_d   = C2X;
                    c2y_d   = C2Y;
                    score_d = 6'd0;
                    idx_d   = 6'd0;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_REPORT;
                    timeout_d = 1'b1;
                    score_d   = 6'd0;
                    c1x_d     = 4'd0;
                    c1y_d     = 4'd0;
                    c2x_d     = 4'd0;
                    c2y_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SCORE: begin
                if (hit && score_q < 6'(PT_NUM)) begin
                    score_d = score_q + 6'd1;
                end
                if (idx_q == 6'(PT_NUM - 1)) begin
                    state_d = S_REPORT;
                end else begin
                    idx_d = nxt_idx;
                end
            end
            S_REPORT: begin
                res_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset holds the solver in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 6'd0;
            laser_rst_q <= 1'b1;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            c1x_q       <= 4'd0;
            c1y_q       <= 4'd0;
            c2x_q       <= 4'd0;
            c2y_q       <= 4'd0;
            score_q     <= 6'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            laser_rst_q <= laser_rst_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            c1x_q       <= c1x_d;
            c1y_q       <= c1y_d;
            c2x_q       <= c2x_d;
            c2y_q       <= c2y_d;
            score_q     <= score_d;
            timeout_q   <= timeout_d;
        end
    end

    assign LASER_RST = laser_rst_q;
    assign X         = x_q;
    assign Y         = y_q;
    assign BUSY      = busy_q;
    assign RES_VALID = res_valid_q;
    assign RES_C1X   = c1x_q;
    assign RES_C1Y   = c1y_q;
    assign RES_C2X   = c2x_q;
    assign RES_C2Y   = c2y_q;
    assign SCORE     = score_q;
    assign TIMEOUT   = timeout_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_laser_pt_source.sv
`timescale 1ns/1ps
// Directed bench for laser_pt_source: streaming, scoring, boundary radius,
// timeout, ignored requests while busy, and mid-run reset.
module tb_laser_pt_source;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic [3:0] wr_x = 4'd0, wr_y = 4'd0;
    logic       start = 1'b0;
    logic       laser_rst;
    logic [3:0] x, y;
    logic [3:0] c1x = 4'd0, c1y = 4'd0, c2x = 4'd0, c2y = 4'd0;
    logic       done = 1'b0;
    logic       busy, res_valid;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic [5:0] score;
    logic       timeout;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_x [40];
    logic [3:0] exp_y [40];

    laser_pt_source dut (
        .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_X(wr_x), .WR_Y(wr_y), .START(start), .LASER_RST(laser_rst),
        .X(x), .Y(y), .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y),
        .DONE(done), .BUSY(busy), .RES_VALID(res_valid),
        .RES_C1X(res_c1x), .RES_C1Y(res_c1y), .RES_C2X(res_c2x), .RES_C2Y(res_c2y),
        .SCORE(score), .TIMEOUT(timeout), .DBG_STATE(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_pt(input int a, input logic [3:0] px, input logic [3:0] py);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'(a); wr_x = px; wr_y = py;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 40) begin exp_x[a] = px; exp_y[a] = py; end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Entered at the first RSTD cycle; leaves at the first WAIT cycle.
    task automatic stream_check(input int inject_at);
        checks++; if (laser_rst !== 1'b1) begin errors++; $display("FAIL rstd1_laser_rst: got %0b expected 1", laser_rst); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstd1_busy: got %0b expected 1", busy); end
        @(negedge clk);
        checks++; if (laser_rst !== 1'b1) begin errors++; $display("FAIL rstd2_laser_rst: got %0b expected 1", laser_rst); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == inject_at + 1) begin start = 1'b0; wr_en = 1'b0; end
            checks++;
            if (x !== exp_x[i] || y !== exp_y[i] || laser_rst !== 1'b0) begin
                errors++;
                $display("FAIL stream[%0d]: got x=%0d y=%0d rst=%0b expected x=%0d y=%0d rst=0",
                         i, x, y, laser_rst, exp_x[i], exp_y[i]);
            end
            if (i == inject_at) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_x = 4'd15; wr_y = 4'd15;
            end
        end
        @(negedge clk);
        checks++; if (x !== 4'd0 || y !== 4'd0) begin errors++; $display("FAIL stream_end: got x=%0d y=%0d expected 0 0", x, y); end
    endtask

    // Entered at WAIT cycle 0; DONE is sampled in WAIT cycle wait_k.
    task automatic finish_run(input int wait_k, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input int exp_score);
        int lat;
        repeat (wait_k) @(negedge clk);
        c1x = a; c1y = b; c2x = c; c2y = d; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        checks++; if (lat != 41) begin errors++; $display("FAIL done_to_res_valid: got %0d cycles expected 41", lat); end
        checks++; if (score !== 6'(exp_score)) begin errors++; $display("FAIL score: got %0d expected %0d", score, exp_score); end
        checks++; if (res_c1x !== a || res_c1y !== b) begin errors++; $display("FAIL res_c1: got (%0d,%0d) expected (%0d,%0d)", res_c1x, res_c1y, a, b); end
        checks++; if (res_c2x !== c || res_c2y !== d) begin errors++; $display("FAIL res_c2: got (%0d,%0d) expected (%0d,%0d)", res_c2x, res_c2y, c, d); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL run_timeout: got %0b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_valid: got %0b expected 0", busy); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL res_valid_pulse: got %0b expected 0", res_valid); end
        checks++; if (score !== 6'(exp_score)) begin errors++; $display("FAIL score_hold: got %0d expected %0d", score, exp_score); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (laser_rst !== 1'b1) begin errors++; $display("FAIL reset_laser_rst: got %0b expected 1", laser_rst); end
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%0b valid=%0b to=%0b expected 0 0 0", busy, res_valid, timeout); end
        checks++; if (x !== 4'd0 || y !== 4'd0 || score !== 6'd0 || res_c1x !== 4'd0 || res_c2y !== 4'd0) begin errors++; $display("FAIL reset_data: got x=%0d y=%0d score=%0d expected 0", x, y, score); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (laser_rst !== 1'b0) begin errors++; $display("FAIL idle_laser_rst: got %0b expected 0", laser_rst); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40; i++) write_pt(i, 4'(i % 16), 4'(i / 16));
        do_start();
        stream_check(-1);
        finish_run(5, 4'd4, 4'd4, 4'd11, 4'd4, 19);
    endtask

    task automatic test_score();
        for (int i = 0; i < 40; i++) begin
            if (i < 20)      write_pt(i, 4'd4, 4'd4);
            else if (i < 35) write_pt(i, 4'd11, 4'd5);
            else             write_pt(i, 4'd0, 4'd15);
        end
        do_start();
        stream_check(-1);
        finish_run(100, 4'd4, 4'd4, 4'd11, 4'd4, 35);
    endtask

    task automatic test_boundary();
        write_pt(0, 4'd8, 4'd4);
        write_pt(1, 4'd8, 4'd5);
        for (int i = 2; i < 40; i++) write_pt(i, 4'd4, 4'd4);
        do_start();
        stream_check(-1);
        finish_run(3, 4'd4, 4'd4, 4'd4, 4'd4, 39);
    endtask

    task automatic test_timeout();
        int n;
        do_start();
        n = 0;
        repeat (10) begin @(negedge clk); n++; end
        c1x = 4'd7; c1y = 4'd7; c2x = 4'd7; c2y = 4'd7; done = 1'b1;
        @(negedge clk); n++;
        done = 1'b0;
        while (res_valid !== 1'b1 && n < 9000) begin @(negedge clk); n++; end
        checks++; if (n != 8234) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 8234", n); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0b expected 1", timeout); end
        checks++; if (score !== 6'd0) begin errors++; $display("FAIL timeout_score: got %0d expected 0", score); end
        checks++; if (res_c1x !== 4'd0 || res_c1y !== 4'd0 || res_c2x !== 4'd0 || res_c2y !== 4'd0) begin errors++; $display("FAIL timeout_res: got %0d %0d %0d %0d expected 0 0 0 0", res_c1x, res_c1y, res_c2x, res_c2y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %0b expected 0", busy); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold: got valid=%0b to=%0b expected 0 1", res_valid, timeout); end
    endtask

    task automatic test_busy_ignore();
        do_start();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL start_clears_timeout: got %0b expected 0", timeout); end
        stream_check(2);
        finish_run(2, 4'd4, 4'd4, 4'd4, 4'd4, 39);
    endtask

    task automatic test_reset_midrun();
        int hits;
        write_pt(45, 4'd15, 4'd15);
        do_start();
        stream_check(-1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (laser_rst !== 1'b1) begin errors++; $display("FAIL abort_laser_rst: got %0b expected 1", laser_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        repeat (60) begin @(negedge clk); if (res_valid === 1'b1) hits++; end
        checks++; if (hits != 0) begin errors++; $display("FAIL abort_res_valid: got %0d pulses expected 0", hits); end
        checks++; if (busy !== 1'b0 || laser_rst !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%0b rst=%0b expected 0 0", busy, laser_rst); end
        do_start();
        stream_check(-1);
        finish_run(100, 4'd4, 4'd4, 4'd4, 4'd4, 39);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_score();
        test_boundary();
        test_timeout();
        test_busy_ignore();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
